// File: rtl/gate_pkg.sv
// Shared definitions for the gate vector sequencer: FSM states, gate bit
// positions in the result bus, and the mismatch popcount.
package gate_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int GATE_BUF  = 0;
  localparam int GATE_NOT  = 1;
  localparam int GATE_AND  = 2;
  localparam int GATE_OR   = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_NAND = 5;
  localparam int GATE_XOR  = 6;
  localparam int GATE_XNOR = 7;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Golden two-input gate bank: the result every healthy bank should return
// for inputs i1, i2.
module gate_expect
  import gate_pkg::*;
(
  input  logic       i1,
  input  logic       i2,
  output logic [7:0] exp
);

  always_comb begin
    exp            = '0;
    exp[GATE_BUF]  = i1;
    exp[GATE_NOT]  = ~i1;
    exp[GATE_AND]  = i1 & i2;
    exp[GATE_OR]   = i1 | i2;
    exp[GATE_NOR]  = ~(i1 | i2);
    exp[GATE_NAND] = ~(i1 & i2);
    exp[GATE_XOR]  = i1 ^ i2;
    exp[GATE_XNOR] = ~(i1 ^ i2);
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Walks a latched list of 2-bit vectors through an external gate bank,
// lets each settle, and scores the bank against the golden gate model.
module gate_vector_sequencer
  import gate_pkg::*;
#(
  parameter int NVEC       = 4,
  parameter int SETTLE_CYC = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*NVEC-1:0] vectors,
  output logic [1:0]        gate_in,
  input  logic [7:0]        gate_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [5:0]        err_count,
  output logic [7:0]        fail_mask,
  output logic [3:0]        vec_idx
);

  localparam logic [3:0] LAST_IDX    = 4'(NVEC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t            state, state_nxt;
  logic [2*NVEC-1:0] vec_lat;
  logic [7:0]        settle_cnt;
  logic [1:0]        cur_vec;
  logic [7:0]        expected;
  logic [7:0]        mismatch;
  logic [6:0]        err_sum;
  logic [5:0]        err_sat;

  gate_expect u_expect (
    .i1  (gate_in[1]),
    .i2  (gate_in[0]),
    .exp (expected)
  );

  always_comb begin
    cur_vec = '0;
    for (int i = 0; i < NVEC; i++) begin
      if (vec_idx == 4'(i)) cur_vec = vec_lat[2*i +: 2];
    end
  end

  // Scoring: gate_in has been stable for the whole settle window by CAPTURE
  assign mismatch = gate_out ^ expected;
  assign err_sum  = {1'b0, err_count} + {3'b000, popcount8(mismatch)};
  assign err_sat  = (err_sum > 7'd63) ? 6'd63 : err_sum[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_APPLY;
      S_APPLY:   state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = (vec_idx == 4'd0) ? S_DONE : S_APPLY;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // The vector copy is pure data and only meaningful once a run is accepted
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) vec_lat <= vectors;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_in    <= 2'b00;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
      vec_idx    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_idx    <= LAST_IDX;
            err_count  <= '0;
            fail_mask  <= '0;
            pass       <= 1'b0;
            settle_cnt <= '0;
          end
        end
        S_APPLY: begin
          gate_in    <= cur_vec;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
        end
        S_CAPTURE: begin
          err_count <= err_sat;
          fail_mask <= fail_mask | mismatch;
          if (vec_idx != 4'd0) vec_idx <= vec_idx - 4'd1;
        end
        S_DONE: begin
          pass <= (err_count == 6'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer: a behavioural gate bank (with an
// optional stuck xor) feeds a 4-vector instance, an inverted bank feeds a 16-vector one.
module tb_gate_vector_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  vectors;
  logic [1:0]  gate_in;
  logic [7:0]  gate_out;
  logic        busy, done, pass;
  logic [5:0]  err_count;
  logic [7:0]  fail_mask;
  logic [3:0]  vec_idx;
  logic        xor_stuck;

  logic        start16;
  logic [31:0] vectors16;
  logic [1:0]  gate_in16;
  logic [7:0]  gate_out16;
  logic        busy16, done16, pass16;
  logic [5:0]  err_count16;
  logic [7:0]  fail_mask16;
  logic [3:0]  vec_idx16;

  int n_vec;
  int n_miss;

  gate_vector_sequencer #(.NVEC(4), .SETTLE_CYC(5)) dut (
    .clk(clk), .rst(rst), .start(start), .vectors(vectors),
    .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_mask(fail_mask), .vec_idx(vec_idx)
  );

  gate_vector_sequencer #(.NVEC(16), .SETTLE_CYC(1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .vectors(vectors16),
    .gate_in(gate_in16), .gate_out(gate_out16), .busy(busy16), .done(done16),
    .pass(pass16), .err_count(err_count16), .fail_mask(fail_mask16), .vec_idx(vec_idx16)
  );

  // Hand-tabulated bank, bits 7..0 = xnor xor nand nor or and not buf
  function automatic logic [7:0] bank(input logic [1:0] ab);
    case (ab)
      2'b00:   return 8'hB2;
      2'b01:   return 8'h6A;
      2'b10:   return 8'h69;
      default: return 8'h8D;
    endcase
  endfunction

  assign gate_out   = xor_stuck ? (bank(gate_in) & 8'hBF) : bank(gate_in);
  assign gate_out16 = ~bank(gate_in16);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one run on the 4-vector instance and watches it for ncyc cycles;
  // seq collects gate_in sampled mid-settle of each vector.
  task automatic run_dut4(input int repulse_at, input bit chg_vec, input int ncyc,
                          output int first_done, output int ndone, output logic [7:0] seq);
    first_done = -1;
    ndone      = 0;
    seq        = 8'hxx;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == repulse_at);
      if (chg_vec && c == 1) vectors = 8'hFF;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (c % 7 == 4 && c <= 25) seq[7 - 2*((c - 4) / 7) -: 2] = gate_in;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL reset_pass: got %b expected 0", pass); end
    n_vec++; if (gate_in !== 2'b00) begin n_miss++; $display("FAIL reset_gate_in: got %b expected 00", gate_in); end
    n_vec++; if (err_count !== 6'd0) begin n_miss++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    n_vec++; if (fail_mask !== 8'h00) begin n_miss++; $display("FAIL reset_fail_mask: got %h expected 00", fail_mask); end
    n_vec++; if (vec_idx !== 4'd0) begin n_miss++; $display("FAIL reset_vec_idx: got %0d expected 0", vec_idx); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ideal;
    int fd, nd;
    logic [7:0] seq;
    vectors   = 8'b00011011;
    xor_stuck = 1'b0;
    run_dut4(0, 1'b0, 40, fd, nd, seq);
    n_vec++; if (seq !== 8'b00011011) begin n_miss++; $display("FAIL ideal_sequence: got %b expected 00011011", seq); end
    n_vec++; if (fd !== 29) begin n_miss++; $display("FAIL ideal_done_cycle: got %0d expected 29", fd); end
    n_vec++; if (nd !== 1) begin n_miss++; $display("FAIL ideal_done_count: got %0d expected 1", nd); end
    n_vec++; if (pass !== 1'b1) begin n_miss++; $display("FAIL ideal_pass: got %b expected 1", pass); end
    n_vec++; if (err_count !== 6'd0) begin n_miss++; $display("FAIL ideal_err_count: got %0d expected 0", err_count); end
    n_vec++; if (fail_mask !== 8'h00) begin n_miss++; $display("FAIL ideal_fail_mask: got %h expected 00", fail_mask); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL ideal_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stuck_xor;
    int fd, nd;
    logic [7:0] seq;
    vectors   = 8'b00011011;
    xor_stuck = 1'b1;
    run_dut4(0, 1'b0, 40, fd, nd, seq);
    xor_stuck = 1'b0;
    n_vec++; if (err_count !== 6'd2) begin n_miss++; $display("FAIL stuck_err_count: got %0d expected 2", err_count); end
    n_vec++; if (fail_mask !== 8'b01000000) begin n_miss++; $display("FAIL stuck_fail_mask: got %b expected 01000000", fail_mask); end
    n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL stuck_pass: got %b expected 0", pass); end
    n_vec++; if (fd !== 29) begin n_miss++; $display("FAIL stuck_done_cycle: got %0d expected 29", fd); end
    repeat (5) @(negedge clk);
    n_vec++; if (err_count !== 6'd2) begin n_miss++; $display("FAIL stuck_hold_err: got %0d expected 2", err_count); end
  endtask

  task automatic test_busy_start;
    int fd, nd;
    logic [7:0] seq;
    vectors = 8'b00011011;
    run_dut4(10, 1'b0, 45, fd, nd, seq);
    n_vec++; if (fd !== 29) begin n_miss++; $display("FAIL busy_start_done_cycle: got %0d expected 29", fd); end
    n_vec++; if (nd !== 1) begin n_miss++; $display("FAIL busy_start_done_count: got %0d expected 1", nd); end
    n_vec++; if (seq !== 8'b00011011) begin n_miss++; $display("FAIL busy_start_sequence: got %b expected 00011011", seq); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL busy_start_second_run: busy got %b expected 0", busy); end
    n_vec++; if (pass !== 1'b1) begin n_miss++; $display("FAIL busy_start_pass: got %b expected 1", pass); end
  endtask

  task automatic test_latch;
    int fd, nd;
    logic [7:0] seq;
    vectors = 8'b00011011;
    run_dut4(0, 1'b1, 40, fd, nd, seq);
    n_vec++; if (seq !== 8'b00011011) begin n_miss++; $display("FAIL latch_sequence: got %b expected 00011011", seq); end
    n_vec++; if (fd !== 29) begin n_miss++; $display("FAIL latch_done_cycle: got %0d expected 29", fd); end
    vectors = 8'b00011011;
  endtask

  task automatic test_reset_mid_settle;
    int nd;
    bit busy_seen;
    nd = 0;
    busy_seen = 1'b0;
    vectors = 8'b00011011;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++; if (gate_in !== 2'b01) begin n_miss++; $display("FAIL mid_pre_gate_in: got %b expected 01", gate_in); end
    n_vec++; if (vec_idx !== 4'd2) begin n_miss++; $display("FAIL mid_pre_vec_idx: got %0d expected 2", vec_idx); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    n_vec++; if (gate_in !== 2'b00) begin n_miss++; $display("FAIL mid_rst_gate_in: got %b expected 00", gate_in); end
    n_vec++; if (vec_idx !== 4'd0) begin n_miss++; $display("FAIL mid_rst_vec_idx: got %0d expected 0", vec_idx); end
    n_vec++; if ({done, pass, err_count, fail_mask} !== 16'h0000) begin
      n_miss++; $display("FAIL mid_rst_status: got %h expected 0000", {done, pass, err_count, fail_mask});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) busy_seen = 1'b1;
    end
    n_vec++; if (nd !== 0) begin n_miss++; $display("FAIL mid_no_done: got %0d pulses expected 0", nd); end
    n_vec++; if (busy_seen !== 1'b0) begin n_miss++; $display("FAIL mid_stays_idle: busy seen %b expected 0", busy_seen); end
  endtask

  task automatic test_saturation;
    int fd;
    fd = -1;
    vectors16 = 32'h1B1B1B1B;
    @(negedge clk);
    start16 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (done16 && fd < 0) fd = c;
    end
    n_vec++; if (fd !== 49) begin n_miss++; $display("FAIL sat_done_cycle: got %0d expected 49", fd); end
    n_vec++; if (err_count16 !== 6'd63) begin n_miss++; $display("FAIL sat_err_count: got %0d expected 63", err_count16); end
    n_vec++; if (fail_mask16 !== 8'hFF) begin n_miss++; $display("FAIL sat_fail_mask: got %h expected ff", fail_mask16); end
    n_vec++; if (pass16 !== 1'b0) begin n_miss++; $display("FAIL sat_pass: got %b expected 0", pass16); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd;
    d1 = -1; d2 = -1; nd = 0;
    vectors = 8'b00011011;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    start = 1'b0;
    n_vec++; if (nd !== 2) begin n_miss++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
    n_vec++; if (d1 !== 29) begin n_miss++; $display("FAIL b2b_first_done: got %0d expected 29", d1); end
    n_vec++; if (d2 !== 59) begin n_miss++; $display("FAIL b2b_second_done: got %0d expected 59", d2); end
    n_vec++; if (pass !== 1'b1) begin n_miss++; $display("FAIL b2b_pass: got %b expected 1", pass); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL b2b_stop: busy got %b expected 0", busy); end
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    start16   = 1'b0;
    vectors   = 8'h00;
    vectors16 = 32'h0;
    xor_stuck = 1'b0;
    test_reset;
    test_ideal;
    test_stuck_xor;
    test_busy_start;
    test_latch;
    test_reset_mid_settle;
    test_saturation;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
GATE_VECTOR_SEQUENCER -- requirements
Module: gate_vector_sequencer

Interface
REQ-001 Parameter NVEC, default 4, is the number of 2-bit test vectors per run (1..16).
REQ-002 Parameter SETTLE_CYC, default 5, is the number of wait cycles between applying a vector and sampling the result (1..255).
REQ-003 Design decision: the block has one clock, and its reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 start  in  1  requests a run; sampled only in IDLE.
REQ-007 vectors  in  2*NVEC  packed vector list; vector i = {vectors[2i+1], vectors[2i]}.
REQ-008 gate_in  out  2  registered drive to the gate bank, {i1,i2}.
REQ-009 gate_out  in  8  gate bank results, bit0..7 = buf, not, and, or, nor, nand, xor, xnor.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse at end of run.
REQ-012 pass  out  1  high when the last completed run had zero mismatches.
REQ-013 err_count  out  6  total mismatched gate bits in the current or last run.
REQ-014 fail_mask  out  8  sticky per-gate mismatch flags for the current or last run.
REQ-015 vec_idx  out  4  index of the vector currently applied.

Function
REQ-016 FSM states: IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-017 IDLE with start=1 -> APPLY; the block latches vectors, sets vec_idx=NVEC-1, clears err_count and fail_mask, and clears pass.
REQ-018 APPLY drives gate_in = {vectors[2*vec_idx+1], vectors[2*vec_idx]}, then goes to SETTLE for exactly one cycle of APPLY.
REQ-019 SETTLE counts SETTLE_CYC cycles, then goes to CAPTURE; gate_in is held constant.
REQ-020 CAPTURE compares gate_out against expected = {i1 xnor i2, i1 xor i2, i1 nand i2, i1 nor i2, i1|i2, i1&i2, ~i1, i1}.
REQ-021 CAPTURE adds the popcount of the mismatches to err_count, saturating at 63.
REQ-022 CAPTURE ORs the mismatch vector into fail_mask.
REQ-023 CAPTURE with vec_idx==0 goes to DONE; otherwise it decrements vec_idx and goes to APPLY.
REQ-024 DONE asserts done for one cycle, sets pass = (err_count==0 including this run), then goes to IDLE.
REQ-025 Per-vector time is SETTLE_CYC+2 cycles; start-accept to done is NVEC*(SETTLE_CYC+2)+1 cycles.
REQ-026 start asserted while busy is ignored, and the run in progress is unaffected.
REQ-027 A change on vectors during a run has no effect; only the latched copy is used.
REQ-028 start held high continuously restarts a run on the cycle after DONE.
REQ-029 err_count, fail_mask, and pass hold their values in IDLE until the next accepted start.

Reset
REQ-030 rst=1 forces state=IDLE immediately, regardless of clk.
REQ-031 rst=1 forces gate_in=2'b00, busy=0, done=0, pass=0, err_count=0, fail_mask=0, vec_idx=0, and clears the settle counter.
REQ-032 rst asserted mid-run aborts the run with no done pulse; the block restarts only on a new start after rst deasserts.

Structure
REQ-033 A shared package gate_pkg holds the state enum and the gate bit-index constants (GATE_BUF=0 .. GATE_XNOR=7).
REQ-034 The expected-result function is one combinational sub-module, gate_expect (inputs i1, i2; output exp[7:0]), reused by benches as the golden model.
REQ-035 The popcount of the 8-bit mismatch vector is a function in gate_pkg.

Verification
REQ-036 Reset mid-SETTLE: start, then rst during vector 2 -> all outputs are 0 within the same cycle, no done pulse, IDLE after release.
REQ-037 Ideal bank: vectors=8'b00011011, correct gates -> gate_in sequence 00,01,10,11; done at cycle 29; pass=1; err_count=0; fail_mask=0.
REQ-038 Stuck-at fault: xor output tied to 0, vectors=8'b00011011 -> err_count=2, fail_mask=8'b01000000, pass=0.
REQ-039 Busy start: start re-pulsed at cycle 10 of a run -> the run completes at cycle 29, and there is no second run.
REQ-040 Saturation: NVEC=16, gate_out inverted from expected -> err_count=63, fail_mask=8'hFF.
REQ-041 Latch check: vectors changed to 8'hFF one cycle after start -> the applied gate_in sequence still matches the original 8'b00011011.
